// File: rtl/nn_pkg.sv
// Shared types and default widths for the sequential neuron dot-product block.
package nn_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int ADDR_W_DEFAULT = 8;
   // 15 * 255 * 255 = 975375 fits in 20 bits
   localparam int ACC_W_DEFAULT  = 20;

endpackage

// File: rtl/neuron_mac_seq_if.sv
// Job request, activation stream, weight-memory and result handshake bundle.
interface neuron_mac_seq_if
   import nn_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEFAULT,
   parameter int ACC_W  = ACC_W_DEFAULT
);
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic [3:0]        count;
   logic [7:0]        x_data;
   logic              x_valid;
   logic              x_ready;
   logic [ADDR_W-1:0] rom_address;
   logic              rom_enable;
   logic [7:0]        rom_data;
   logic [ACC_W-1:0]  result;
   logic              out_valid;
   logic              out_ready;
   logic              busy;

   modport slave (
      input  start, base_addr, count, x_data, x_valid, rom_data, out_ready,
      output x_ready, rom_address, rom_enable, result, out_valid, busy
   );

   modport master (
      output start, base_addr, count, x_data, x_valid, rom_data, out_ready,
      input  x_ready, rom_address, rom_enable, result, out_valid, busy
   );
endinterface

// File: rtl/nn_mac8.sv
// 8x8 unsigned multiply-accumulate with synchronous clear (clear wins over enable).
module nn_mac8
   import nn_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [7:0]       a,
   input  logic [7:0]       b,
   output logic [ACC_W-1:0] acc
);
   logic [15:0] prod;

   assign prod = a * b;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         acc <= '0;
      else if (clr)
         acc <= '0;
      else if (en)
         acc <= acc + ACC_W'(prod);
   end
endmodule

// File: rtl/neuron_mac_seq.sv
// Sequential dot product: streams count activations against weights read from
// base_addr onward, then presents the sum until downstream accepts it.
module neuron_mac_seq
   import nn_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEFAULT,
   parameter int ACC_W  = ACC_W_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   neuron_mac_seq_if.slave bus
);
   state_t            state, state_nxt;
   logic [ADDR_W-1:0] base;
   logic [3:0]        cnt;
   logic [3:0]        idx;
   logic              mac_clr;
   logic              xfer;
   logic              fetch_on;
   logic              done_on;
   logic [ACC_W-1:0]  acc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         base <= '0;
         cnt  <= '0;
         idx  <= '0;
      end else if (state == IDLE && bus.start) begin
         base <= bus.base_addr;
         cnt  <= bus.count;
         idx  <= '0;
      end else if (xfer) begin
         idx  <= idx + 4'd1;
      end
   end

   always_comb begin
      state_nxt = state;
      mac_clr   = 1'b0;
      xfer      = 1'b0;
      fetch_on  = 1'b0;
      done_on   = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               mac_clr   = 1'b1;
               state_nxt = (bus.count == 4'd0) ? DONE : FETCH;
            end
         end
         FETCH: begin
            fetch_on = 1'b1;
            xfer     = bus.x_valid;
            if (xfer && idx == cnt - 4'd1)
               state_nxt = DONE;
         end
         DONE: begin
            done_on = 1'b1;
            if (bus.out_ready)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Accumulator doubles as the result register: it holds through DONE and IDLE
   nn_mac8 #(.ACC_W(ACC_W)) u_mac (
      .clk (clk),
      .rst (rst),
      .clr (mac_clr),
      .en  (xfer),
      .a   (bus.x_data),
      .b   (bus.rom_data),
      .acc (acc)
   );

   assign bus.x_ready     = fetch_on;
   assign bus.rom_enable  = fetch_on;
   assign bus.rom_address = fetch_on ? base + ADDR_W'(idx) : '0;
   assign bus.out_valid   = done_on;
   assign bus.busy        = (state != IDLE);
   assign bus.result      = acc;
endmodule

// File: tb/tb_neuron_mac_seq.sv
// Directed bench for neuron_mac_seq with a per-cycle reference model and literal job sums.
module tb_neuron_mac_seq;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   neuron_mac_seq_if #(.ADDR_W(8), .ACC_W(20)) bus ();

   neuron_mac_seq #(.ADDR_W(8), .ACC_W(20)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   logic [7:0] rom [256];
   assign bus.rom_data = rom[bus.rom_address];

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   int xs [16];
   bit en_seen = 1'b0;
   int addr_log [$];

   // reference: phase 0 idle, 1 consuming terms, 2 holding result
   int m_ph = 0, m_k = 0, m_n = 0, m_base = 0, m_sum = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_ph <= 0; m_k <= 0; m_n <= 0; m_base <= 0; m_sum <= 0;
      end else begin
         case (m_ph)
            0: if (bus.start) begin
               m_sum  <= 0;
               m_k    <= 0;
               m_n    <= int'(bus.count);
               m_base <= int'(bus.base_addr);
               m_ph   <= (bus.count == 4'd0) ? 2 : 1;
            end
            1: if (bus.x_valid) begin
               m_sum <= m_sum + int'(bus.x_data) * int'(rom[(m_base + m_k) % 256]);
               m_k   <= m_k + 1;
               if (m_k + 1 == m_n) m_ph <= 2;
            end
            default: if (bus.out_ready) m_ph <= 0;
         endcase
      end
   end

   always @(negedge clk) begin
      check("busy",        32'(bus.busy),        32'(m_ph != 0));
      check("x_ready",     32'(bus.x_ready),     32'(m_ph == 1));
      check("rom_enable",  32'(bus.rom_enable),  32'(m_ph == 1));
      check("out_valid",   32'(bus.out_valid),   32'(m_ph == 2));
      check("rom_address", 32'(bus.rom_address), (m_ph == 1) ? 32'((m_base + m_k) % 256) : 32'd0);
      if (m_ph != 1) check("result", 32'(bus.result), 32'(m_sum));
      if (bus.rom_enable) en_seen = 1'b1;
      if (bus.rom_enable && bus.x_valid) addr_log.push_back(int'(bus.rom_address));
   end

   // Entered and left just after a rising edge; exp_lat < 0 skips the latency check.
   task automatic run_job(input logic [7:0] b, input logic [3:0] n, input bit stall,
                          input int hold, input int exp_res, input int exp_lat, input string nm);
      int t0;
      int g;
      bus.start = 1'b1; bus.base_addr = b; bus.count = n; bus.x_valid = 1'b0;
      t0 = cyc;
      @(posedge clk); #1;
      bus.start = 1'b0;
      g = 0;
      while (m_k < int'(n) && m_ph == 1 && g < 100) begin
         bus.x_data  = 8'(xs[m_k]);
         bus.x_valid = !(stall && (g % 2 == 1));
         @(posedge clk); #1;
         g++;
      end
      bus.x_valid = 1'b0;
      g = 0;
      @(negedge clk);
      while (!bus.out_valid && g < 40) begin
         @(negedge clk);
         g++;
      end
      if (!bus.out_valid) begin
         n_cmp++; n_err++;
         $display("FAIL %s_timeout: out_valid never rose", nm);
      end else begin
         if (exp_lat >= 0) check({nm, "_latency"}, 32'(cyc - t0), 32'(exp_lat));
         check({nm, "_result"}, 32'(bus.result), 32'(exp_res));
      end
      // start during DONE and during the handshake cycle must both be ignored
      bus.start = 1'b1; bus.base_addr = 8'h33; bus.count = 4'd5;
      repeat (hold) @(negedge clk);
      check({nm, "_held"}, 32'(bus.result), 32'(exp_res));
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      bus.start     = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      bus.start = 1'b0; bus.base_addr = '0; bus.count = '0;
      bus.x_data = '0; bus.x_valid = 1'b0; bus.out_ready = 1'b0;
      for (int i = 0; i < 256; i++) rom[i] = 8'd0;
      rom[0] = 8'd1; rom[1] = 8'd3; rom[2] = 8'd2; rom[3] = 8'd5;
      rom[4] = 8'd6; rom[5] = 8'd5; rom[6] = 8'd5; rom[7] = 8'd2;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // start in the very first cycle after reset release
      for (int i = 0; i < 16; i++) xs[i] = 1;
      run_job(8'd0, 4'd8, 1'b0, 0, 29, 9, "const");

      for (int i = 0; i < 16; i++) xs[i] = i + 1;
      run_job(8'd0, 4'd8, 1'b1, 0, 144, -1, "stall");

      en_seen = 1'b0;
      run_job(8'd0, 4'd0, 1'b0, 0, 0, 1, "zero");
      check("zero_no_rom_enable", 32'(en_seen), 32'd0);

      rom[254] = 8'd255; rom[255] = 8'd255;
      for (int i = 0; i < 16; i++) xs[i] = 255;
      addr_log.delete();
      // 255 * (255 + 255 + 1 + 3)
      run_job(8'd254, 4'd4, 1'b0, 0, 131070, 5, "wrap");
      check("wrap_naddr", 32'(addr_log.size()), 32'd4);
      if (addr_log.size() == 4) begin
         check("wrap_addr0", 32'(addr_log[0]), 32'd254);
         check("wrap_addr1", 32'(addr_log[1]), 32'd255);
         check("wrap_addr2", 32'(addr_log[2]), 32'd0);
         check("wrap_addr3", 32'(addr_log[3]), 32'd1);
      end

      for (int i = 0; i < 256; i++) rom[i] = 8'd255;
      run_job(8'd250, 4'd15, 1'b0, 5, 975375, 16, "max");
      for (int i = 0; i < 256; i++) rom[i] = 8'd0;
      rom[0] = 8'd1; rom[1] = 8'd3; rom[2] = 8'd2; rom[3] = 8'd5;
      rom[4] = 8'd6; rom[5] = 8'd5; rom[6] = 8'd5; rom[7] = 8'd2;

      // abort a job after three terms
      for (int i = 0; i < 16; i++) xs[i] = 1;
      bus.start = 1'b1; bus.base_addr = 8'd0; bus.count = 4'd8;
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int g = 0; g < 20 && m_k < 3; g++) begin
         bus.x_data = 8'd1; bus.x_valid = 1'b1;
         @(posedge clk); #1;
      end
      bus.x_valid = 1'b0;
      check("pre_rst_busy", 32'(bus.busy), 32'd1);
      rst = 1'b1;
      #1;
      check("rst_busy",        32'(bus.busy),        32'd0);
      check("rst_result",      32'(bus.result),      32'd0);
      check("rst_out_valid",   32'(bus.out_valid),   32'd0);
      check("rst_x_ready",     32'(bus.x_ready),     32'd0);
      check("rst_rom_enable",  32'(bus.rom_enable),  32'd0);
      check("rst_rom_address", 32'(bus.rom_address), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      run_job(8'd0, 4'd8, 1'b0, 0, 29, 9, "post_rst");

      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
